// File: rtl/pipe_regfile_if.sv
// Decode/writeback bundle for the Y86-64 pipelined register file.
// The master side (pipeline control) drives indices and write data; the slave side is the regfile.
interface pipe_regfile_if #(
  parameter int unsigned DATA_W = 64
);
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic              busyA;
  logic              busyB;
  logic              iss_en;
  logic [3:0]        iss_dstE;
  logic [3:0]        iss_dstM;
  logic [3:0]        dstE;
  logic [DATA_W-1:0] valE;
  logic              Cnd;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valM;
  logic              err;

  modport master (
    output srcA, srcB, iss_en, iss_dstE, iss_dstM, dstE, valE, Cnd, dstM, valM,
    input  valA, valB, busyA, busyB, err
  );

  modport slave (
    input  srcA, srcB, iss_en, iss_dstE, iss_dstM, dstE, valE, Cnd, dstM, valM,
    output valA, valB, busyA, busyB, err
  );
endinterface

// File: rtl/pipe_regfile.sv
// Y86-64 register file: two bypassed read ports, E/M write ports with cmov gating,
// and a per-register pending-write scoreboard feeding decode-stage stall logic.
module pipe_regfile #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       NREG     = 15,
  parameter logic [DATA_W-1:0] RSP_INIT = 'h200,
  parameter int unsigned       CNT_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  pipe_regfile_if.slave rf
);

  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic [1:0]        dec_c  [NREG];
  logic              err_q;
  logic              err_d;
  logic              we_e;
  logic              we_m;

  // Write enables are masked during reset so reads show reset contents only.
  assign we_e = !rst && rf.Cnd && (rf.dstE < 4'(NREG));
  assign we_m = !rst && (rf.dstM < 4'(NREG));

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      dec_c[r] = {1'b0, rf.dstE == 4'(r)} + {1'b0, rf.dstM == 4'(r)};
    end
  end

  always_comb begin
    rf.valA  = '0;
    rf.valB  = '0;
    rf.busyA = 1'b0;
    rf.busyB = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rf.srcA == 4'(r)) begin
        rf.valA  = regs_q[r];
        rf.busyA = int'(cnt_q[r]) > int'(dec_c[r]);
      end
      if (rf.srcB == 4'(r)) begin
        rf.valB  = regs_q[r];
        rf.busyB = int'(cnt_q[r]) > int'(dec_c[r]);
      end
    end
    // M is applied after E so it wins when both target the same register.
    if (we_e && rf.srcA == rf.dstE) rf.valA = rf.valE;
    if (we_e && rf.srcB == rf.dstE) rf.valB = rf.valE;
    if (we_m && rf.srcA == rf.dstM) rf.valA = rf.valM;
    if (we_m && rf.srcB == rf.dstM) rf.valB = rf.valM;
  end

  always_comb begin
    int sum;
    sum   = 0;
    err_d = err_q;
    for (int unsigned r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      if (we_e && rf.dstE == 4'(r)) regs_d[r] = rf.valE;
      if (we_m && rf.dstM == 4'(r)) regs_d[r] = rf.valM;

      sum = int'(cnt_q[r]) - int'(dec_c[r])
          + ((rf.iss_en && rf.iss_dstE == 4'(r)) ? 1 : 0)
          + ((rf.iss_en && rf.iss_dstM == 4'(r)) ? 1 : 0);
      if (sum > CNT_MAX) begin
        cnt_d[r] = CNT_W'(CNT_MAX);
        err_d    = 1'b1;
      end else if (sum < 0) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(sum);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        regs_q[r] <= (r == 4) ? RSP_INIT : '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign rf.err = err_q;

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed plus randomized check of pipe_regfile against a behavioural array/counter model.
module tb_pipe_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_regfile_if #(.DATA_W(64)) bus ();

  pipe_regfile #(
    .DATA_W  (64),
    .NREG    (15),
    .RSP_INIT(64'h200),
    .CNT_W   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rf (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] mreg [15];
  int          mcnt [15];
  logic        merr;

  function automatic void m_reset();
    for (int r = 0; r < 15; r++) begin
      mreg[r] = (r == 4) ? 64'h200 : 64'h0;
      mcnt[r] = 0;
    end
    merr = 1'b0;
  endfunction

  function automatic logic [63:0] m_read(logic [3:0] s);
    if (s >= 4'd15) return 64'h0;
    if (rst) return mreg[s];
    if (bus.dstM == s) return bus.valM;
    if (bus.dstE == s && bus.Cnd) return bus.valE;
    return mreg[s];
  endfunction

  function automatic int retires(logic [3:0] s);
    return ((bus.dstE == s) ? 1 : 0) + ((bus.dstM == s) ? 1 : 0);
  endfunction

  function automatic logic m_busy(logic [3:0] s);
    if (s >= 4'd15) return 1'b0;
    return (mcnt[s] - retires(s)) > 0;
  endfunction

  function automatic void m_update();
    int n;
    if (rst) begin
      m_reset();
      return;
    end
    for (int r = 0; r < 15; r++) begin
      n = mcnt[r] - retires(4'(r));
      if (bus.iss_en && bus.iss_dstE == 4'(r)) n++;
      if (bus.iss_en && bus.iss_dstM == 4'(r)) n++;
      if (n > 3) begin n = 3; merr = 1'b1; end
      if (n < 0) begin n = 0; merr = 1'b1; end
      mcnt[r] = n;
    end
    if (bus.dstE < 4'd15 && bus.Cnd) mreg[bus.dstE] = bus.valE;
    if (bus.dstM < 4'd15) mreg[bus.dstM] = bus.valM;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_valA"},  bus.valA,  m_read(bus.srcA));
    chk({tag, "_valB"},  bus.valB,  m_read(bus.srcB));
    chk({tag, "_busyA"}, 64'(bus.busyA), 64'(m_busy(bus.srcA)));
    chk({tag, "_busyB"}, 64'(bus.busyB), 64'(m_busy(bus.srcB)));
    chk({tag, "_err"},   64'(bus.err),   64'(merr));
  endtask

  task automatic idle();
    bus.iss_en   = 1'b0;
    bus.iss_dstE = 4'hF;
    bus.iss_dstM = 4'hF;
    bus.dstE     = 4'hF;
    bus.dstM     = 4'hF;
    bus.valE     = 64'h0;
    bus.valM     = 64'h0;
    bus.Cnd      = 1'b1;
  endtask

  // Entered at posedge+1; checks at negedge, clocks, updates the model, returns at posedge+1.
  task automatic step(string tag);
    @(negedge clk);
    check_all(tag);
    @(posedge clk);
    m_update();
    #1;
  endtask

  function automatic logic [3:0] ridx();
    if ($urandom_range(0, 5) == 0) return 4'hF;
    return 4'($urandom_range(0, 14));
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    bus.srcA = 4'd4;
    bus.srcB = 4'd0;
    m_reset();
    #2;
    chk("t1_rsp", bus.valA, 64'h200);
    chk("t1_r0", bus.valB, 64'h0);
    chk("t1_busyA", 64'(bus.busyA), 64'h0);
    chk("t1_err", 64'(bus.err), 64'h0);
    #5 rst = 1'b0;
    step("t1_idle");

    // E write with same-cycle bypass
    bus.dstE = 4'd3; bus.valE = 64'h1234; bus.Cnd = 1'b1;
    bus.srcA = 4'd3; bus.srcB = 4'd3;
    #1 chk("t2_bypass", bus.valB, 64'h1234);
    step("t2_w");
    idle();
    #1 chk("t2_stored", bus.valA, 64'h1234);
    step("t2_r");

    // cmov not taken
    bus.dstE = 4'd2; bus.valE = 64'hFF; bus.Cnd = 1'b0; bus.srcA = 4'd2;
    #1 chk("t3_nobyp", bus.valA, 64'h0);
    step("t3_w");
    idle();
    #1 chk("t3_kept", bus.valA, 64'h0);
    step("t3_r");

    // popq %rsp: M beats E
    bus.dstE = 4'd4; bus.valE = 64'h208; bus.dstM = 4'd4; bus.valM = 64'hABCD;
    bus.srcA = 4'd4;
    #1 chk("t4_byp", bus.valA, 64'hABCD);
    step("t4_w");
    idle();
    #1 chk("t4_rsp", bus.valA, 64'hABCD);
    step("t4_r");

    // scoreboard issue/retire on reg 1
    bus.iss_en = 1'b1; bus.iss_dstM = 4'd1; bus.srcA = 4'd1;
    #1 chk("t5_iss_same", 64'(bus.busyA), 64'h0);
    step("t5_iss");
    idle();
    #1 chk("t5_busy", 64'(bus.busyA), 64'h1);
    step("t5_wait");
    bus.dstM = 4'd1; bus.valM = 64'h7;
    #1 chk("t5_ret_busy", 64'(bus.busyA), 64'h0);
    chk("t5_ret_val", bus.valA, 64'h7);
    step("t5_ret");
    idle();
    #1 chk("t5_clear", 64'(bus.busyA), 64'h0);
    step("t5_after");

    // overflow, underflow, reset clears err
    bus.iss_en = 1'b1; bus.iss_dstE = 4'd5; bus.srcA = 4'd5;
    repeat (4) step("t6_iss");
    idle();
    #1 chk("t6_ovf_err", 64'(bus.err), 64'h1);
    bus.dstE = 4'd5;
    #1 chk("t6_sat_busy", 64'(bus.busyA), 64'h1);
    step("t6_ret5");
    idle();
    bus.dstM = 4'd6; bus.srcA = 4'd6;
    step("t6_unf");
    idle();
    #1 chk("t6_err_sticky", 64'(bus.err), 64'h1);
    chk("t6_cnt6", 64'(bus.busyA), 64'h0);
    rst = 1'b1;
    m_reset();
    bus.srcA = 4'd5; bus.srcB = 4'd4;
    #1 chk("t6_rst_err", 64'(bus.err), 64'h0);
    chk("t6_rst_busy", 64'(bus.busyA), 64'h0);
    chk("t6_rst_rsp", bus.valB, 64'h200);
    rst = 1'b0;
    step("t6_post");

    // randomized traffic with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      bus.iss_en   = 1'($urandom_range(0, 1));
      bus.iss_dstE = ridx();
      bus.iss_dstM = ridx();
      bus.dstE     = ridx();
      bus.dstM     = ridx();
      bus.valE     = {$urandom, $urandom};
      bus.valM     = {$urandom, $urandom};
      bus.Cnd      = 1'($urandom_range(0, 1));
      bus.srcA     = ($urandom_range(0, 2) == 0) ? bus.dstM : ridx();
      bus.srcB     = ($urandom_range(0, 2) == 0) ? bus.dstE : ridx();
      if (i == 200) begin
        rst = 1'b1;
        m_reset();
      end
      if (i == 202) rst = 1'b0;
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
